// File: rtl/touch_gen_pkg.sv
// touch_gen_pkg: shared constants for the bouncy touch generator.
//   - state encodings for the generator FSM
//   - LFSR feedback taps and the substitute used for an all-zero seed
//   - lfsr_next(): one step of the 16-bit Galois LFSR
package touch_gen_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    // The top module has a parameter named SETTLE, so the FSM uses these
    // prefixed names to avoid that parameter shadowing the state constant.
    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_BOUNCE = BOUNCE,
        ST_SETTLE = SETTLE
    } state_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

    // Right-shifting Galois form: the bit shifted out selects the tap XOR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = cur >> 1;
        return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// lfsr16_galois: free-running 16-bit Galois LFSR, advances every cycle.
// Ports:
//   clk_out  in   clock
//   rst      in   asynchronous active-high reset (loads the seed)
//   state    out  current 16-bit LFSR value
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr16_galois
    import touch_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_out,
    input  logic        rst,
    output logic [15:0] state
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_ZERO_SUB : SEED;

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= lfsr_next(state);
    end

endmodule

// File: rtl/touch_bounce_gen.sv
// touch_bounce_gen: generates a mechanically bouncy touch waveform.
// On an accepted start, touch_out goes to the requested level, then toggles
// 2*BOUNCE_CNT times at pseudo-random spacing (ending at the requested level),
// then holds for SETTLE cycles before pulsing done.
// Ports:
//   clk_out    in   clock
//   rst        in   asynchronous active-high reset; aborts any sequence
//   start      in   one-cycle command, only looked at while idle
//   level      in   target level, captured on acceptance
//   touch_out  out  registered bouncy touch signal
//   busy       out  high from the cycle after acceptance until done
//   done       out  one-cycle end-of-sequence pulse
//   edge_idx   out  bounce toggles issued in the current/last sequence
module touch_bounce_gen
    import touch_gen_pkg::*;
#(
    parameter int          BOUNCE_CNT = 3,
    parameter logic [19:0] GAP_MIN    = 20'd1000,
    parameter logic [15:0] GAP_MASK   = 16'h0FFF,
    parameter logic [19:0] SETTLE     = 20'd600000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic       level,
    output logic       touch_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] edge_idx
);

    localparam logic [3:0] LAST_EDGE = 4'(2 * BOUNCE_CNT);

    state_t      state, state_nx;
    logic [19:0] cnt, cnt_nx;
    logic        level_q, level_nx;
    logic        touch_nx, busy_nx, done_nx;
    logic [3:0]  edge_nx;
    logic [15:0] lfsr;
    logic [19:0] gap;

    lfsr16_galois #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_out (clk_out),
        .rst     (rst),
        .state   (lfsr)
    );

    // Random part is masked to 16 bits, so zero-extension cannot overflow
    // as long as GAP_MIN + GAP_MASK fits in 20 bits.
    assign gap = GAP_MIN + {4'b0000, lfsr & GAP_MASK};

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            touch_out <= INIT_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
            edge_idx  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            level_q   <= level_nx;
            touch_out <= touch_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            edge_idx  <= edge_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level_q;
        touch_nx = touch_out;
        busy_nx  = busy;
        done_nx  = 1'b0;
        edge_nx  = edge_idx;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    level_nx = level;
                    busy_nx  = 1'b1;
                    edge_nx  = '0;
                    if (level == touch_out) begin
                        // Nothing to drive: zero-length settle, done next edge.
                        state_nx = ST_SETTLE;
                        cnt_nx   = '0;
                    end else begin
                        touch_nx = level;
                        if (BOUNCE_CNT == 0) begin
                            state_nx = ST_SETTLE;
                            cnt_nx   = SETTLE - 20'd1;
                        end else begin
                            state_nx = ST_BOUNCE;
                            cnt_nx   = gap - 20'd1;
                        end
                    end
                end
            end

            ST_BOUNCE: begin
                if (cnt == '0) begin
                    // Toggles come in pairs, so the last one lands on level_q.
                    touch_nx = ~touch_out;
                    edge_nx  = edge_idx + 4'd1;
                    if (edge_idx + 4'd1 == LAST_EDGE) begin
                        state_nx = ST_SETTLE;
                        cnt_nx   = SETTLE - 20'd1;
                    end else begin
                        cnt_nx   = gap - 20'd1;
                    end
                end else begin
                    cnt_nx = cnt - 20'd1;
                end
            end

            ST_SETTLE: begin
                if (cnt == '0) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 20'd1;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_touch_bounce_gen.sv
// tb_touch_bounce_gen: self-checking bench for touch_bounce_gen.
// Three instances: a deterministic burst, a clean single edge, and a
// random-gap generator driving a behavioural debouncer.
module tb_touch_bounce_gen;

    localparam logic [19:0] R_GAP_MIN = 20'd20;
    localparam logic [15:0] R_MASK    = 16'h001F;
    localparam logic [19:0] R_SETTLE  = 20'd300;
    localparam int          DEB_WIN   = 200;

    logic clk_out = 1'b0;
    logic rst     = 1'b1;

    logic start_d = 0, level_d = 0, start_c = 0, level_c = 0, start_r = 0, level_r = 0;
    logic d_touch, d_busy, d_done, c_touch, c_busy, c_done, r_touch, r_busy, r_done;
    logic [3:0] d_eidx, c_eidx, r_eidx;

    int errors = 0;
    int checks = 0;

    always #5 clk_out = ~clk_out;

    touch_bounce_gen #(.BOUNCE_CNT(2), .GAP_MIN(20'd4), .GAP_MASK(16'h0000),
                       .SETTLE(20'd10), .LFSR_SEED(16'hACE1), .INIT_LEVEL(1'b0)) u_det (
        .clk_out(clk_out), .rst(rst), .start(start_d), .level(level_d),
        .touch_out(d_touch), .busy(d_busy), .done(d_done), .edge_idx(d_eidx));

    touch_bounce_gen #(.BOUNCE_CNT(0), .GAP_MIN(20'd4), .GAP_MASK(16'h0000),
                       .SETTLE(20'd10), .LFSR_SEED(16'h0000), .INIT_LEVEL(1'b0)) u_clean (
        .clk_out(clk_out), .rst(rst), .start(start_c), .level(level_c),
        .touch_out(c_touch), .busy(c_busy), .done(c_done), .edge_idx(c_eidx));

    touch_bounce_gen #(.BOUNCE_CNT(3), .GAP_MIN(R_GAP_MIN), .GAP_MASK(R_MASK),
                       .SETTLE(R_SETTLE), .LFSR_SEED(16'hACE1), .INIT_LEVEL(1'b0)) u_rnd (
        .clk_out(clk_out), .rst(rst), .start(start_r), .level(level_r),
        .touch_out(r_touch), .busy(r_busy), .done(r_done), .edge_idx(r_eidx));

    // ---------------- reference pieces ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // LFSR value in use at each counted edge, indexed by edge number.
    logic [15:0] hist [0:32767];
    logic [15:0] mlf;
    int          ecnt = 0;
    always @(posedge clk_out or posedge rst) begin
        if (rst) mlf = 16'hACE1;
        else begin
            hist[ecnt] = mlf;
            mlf = lfsr_step(mlf);
            ecnt++;
        end
    end

    // Behavioural debouncer: output follows input once stable for DEB_WIN cycles.
    logic deb = 1'b0, deb_in = 1'b0;
    int   stab = 0, deb_tog = 0;
    always @(negedge clk_out) begin
        if (rst) begin
            deb = 1'b0; deb_in = 1'b0; stab = 0;
        end else begin
            if (r_touch != deb_in) stab = 0;
            else if (stab < DEB_WIN) stab++;
            deb_in = r_touch;
            if (stab >= DEB_WIN && deb != deb_in) begin
                deb = deb_in;
                deb_tog++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- deterministic burst table ----------------
    typedef struct {
        int         k;
        bit         touch;   // for level=1; inverted for level=0
        bit         busy;
        bit         done;
        logic [3:0] eidx;
    } vec_t;
    vec_t tbl [10];

    // Drive start (unless already armed), then compare table checkpoints at
    // k cycles after the acceptance edge. Optionally inject ignored starts
    // and arm a start coincident with the final sample.
    task automatic run_det(input bit lvl, input bit pre, input int kmax,
                           input int ign_a, input int ign_b,
                           input bit chain, input bit chain_lvl, input string tag);
        if (!pre) begin
            @(negedge clk_out);
            start_d = 1'b1; level_d = lvl;
        end
        @(posedge clk_out);
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk_out);
            start_d = 1'b0;
            level_d = 1'($urandom);
            for (int i = 0; i < 10; i++) begin
                if (tbl[i].k == k) begin
                    chk($sformatf("%s_k%0d", tag, k),
                        {25'd0, d_touch, d_busy, d_done, d_eidx},
                        {25'd0, (lvl ? tbl[i].touch : !tbl[i].touch),
                         tbl[i].busy, tbl[i].done, tbl[i].eidx});
                end
            end
            if (k == ign_a || k == ign_b) begin
                start_d = 1'b1; level_d = 1'($urandom);
            end
            if (chain && k == kmax) begin
                start_d = 1'b1; level_d = chain_lvl;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t, done_e, exp_t, n_obs;
        bit   got_done, exp_lvl, prev, saw_done, moved;
        int   obs [$];
        int   d0;

        tbl[0] = '{0,  1, 1, 0, 4'd0};
        tbl[1] = '{3,  1, 1, 0, 4'd0};
        tbl[2] = '{4,  0, 1, 0, 4'd1};
        tbl[3] = '{7,  0, 1, 0, 4'd1};
        tbl[4] = '{8,  1, 1, 0, 4'd2};
        tbl[5] = '{12, 0, 1, 0, 4'd3};
        tbl[6] = '{16, 1, 1, 0, 4'd4};
        tbl[7] = '{25, 1, 1, 0, 4'd4};
        tbl[8] = '{26, 1, 0, 1, 4'd4};
        tbl[9] = '{27, 1, 0, 0, 4'd4};

        // Reset state
        repeat (3) @(negedge clk_out);
        chk("rst_det", {25'd0, d_touch, d_busy, d_done, d_eidx}, 32'd0);
        chk("rst_rnd", {25'd0, r_touch, r_busy, r_done, r_eidx}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_out);
        chk("idle_det", {25'd0, d_touch, d_busy, d_done, d_eidx}, 32'd0);

        // Deterministic burst to 1
        run_det(1'b1, 1'b0, 27, -1, -1, 1'b0, 1'b0, "burst");

        // No-op: level already matches
        @(negedge clk_out);
        start_d = 1'b1; level_d = 1'b1;
        @(posedge clk_out);
        @(negedge clk_out);
        start_d = 1'b0;
        chk("noop_k0", {25'd0, d_touch, d_busy, d_done, d_eidx}, {25'd0, 1'b1, 1'b1, 1'b0, 4'd0});
        @(negedge clk_out);
        chk("noop_k1", {25'd0, d_touch, d_busy, d_done, d_eidx}, {25'd0, 1'b1, 1'b0, 1'b1, 4'd0});
        @(negedge clk_out);
        chk("noop_k2", {30'd0, d_busy, d_done}, 32'd0);

        // Ignored starts while busy, then start coincident with done
        run_det(1'b0, 1'b0, 26, 5, 20, 1'b1, 1'b1, "ign");
        run_det(1'b1, 1'b1, 27, -1, -1, 1'b0, 1'b0, "chain");

        // Reset mid-burst, then an identical rerun
        @(negedge clk_out); rst = 1'b1;
        @(negedge clk_out); rst = 1'b0;
        run_det(1'b1, 1'b0, 9, -1, -1, 1'b0, 1'b0, "pre_rst");
        rst = 1'b1;
        #1;
        chk("midrst", {25'd0, d_touch, d_busy, d_done, d_eidx}, 32'd0);
        @(negedge clk_out); rst = 1'b0;
        saw_done = 1'b0; moved = 1'b0;
        repeat (40) begin
            @(negedge clk_out);
            if (d_done || d_busy) saw_done = 1'b1;
            if (d_touch) moved = 1'b1;
        end
        chk("midrst_quiet", {30'd0, saw_done, moved}, 32'd0);
        run_det(1'b1, 1'b0, 27, -1, -1, 1'b0, 1'b0, "rerun");

        // Clean single edge
        @(negedge clk_out);
        start_c = 1'b1; level_c = 1'b1;
        @(posedge clk_out);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk_out);
            start_c = 1'b0;
            if (k == 0 || k == 5 || k == 9 || k == 10 || k == 11)
                chk($sformatf("clean_k%0d", k), {25'd0, c_touch, c_busy, c_done, c_eidx},
                    {25'd0, 1'b1, (k < 10), (k == 10), 4'd0});
        end

        // Random gaps into the debouncer
        exp_lvl = r_touch === 1'b1;
        chk("rnd_start_lvl", {31'd0, r_touch}, 32'd0);
        exp_lvl = 1'b0;
        for (int s = 0; s < 10; s++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk_out);
            start_r = 1'b1; level_r = ~exp_lvl;
            @(negedge clk_out);
            start_r = 1'b0;
            t = ecnt - 1;
            d0 = deb_tog;
            chk($sformatf("rnd%0d_contact", s), {31'd0, r_touch}, {31'd0, ~exp_lvl});
            prev = r_touch;
            obs.delete();
            got_done = 1'b0;
            done_e = -1;
            for (int c = 0; c < 2000 && !got_done; c++) begin
                @(negedge clk_out);
                if (r_touch != prev) obs.push_back(ecnt - 1);
                prev = r_touch;
                if (r_done) begin
                    got_done = 1'b1;
                    done_e = ecnt - 1;
                end
            end
            chk($sformatf("rnd%0d_done_seen", s), {31'd0, got_done}, 32'd1);
            n_obs = obs.size();
            chk($sformatf("rnd%0d_ntog", s), n_obs, 32'd6);
            exp_t = t;
            for (int i = 0; i < 6; i++) begin
                exp_t = exp_t + int'(R_GAP_MIN) + int'(hist[exp_t] & R_MASK);
                if (i < n_obs) begin
                    int g;
                    g = obs[i] - ((i == 0) ? t : obs[i-1]);
                    chk($sformatf("rnd%0d_tog%0d", s, i), obs[i], exp_t);
                    chk($sformatf("rnd%0d_gap%0d", s, i),
                        {31'd0, (g >= 20 && g <= 20 + 31)}, 32'd1);
                end
            end
            chk($sformatf("rnd%0d_done_t", s), done_e, exp_t + int'(R_SETTLE));
            chk($sformatf("rnd%0d_deb", s), deb_tog - d0, 32'd1);
            exp_lvl = ~exp_lvl;
            chk($sformatf("rnd%0d_final", s), {31'd0, r_touch}, {31'd0, exp_lvl});
            chk($sformatf("rnd%0d_deb_lvl", s), {31'd0, deb}, {31'd0, exp_lvl});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/touch_bounce_gen.md
Name: touch_bounce_gen

Overview:
- Synthesizable transmitter of a mechanically bouncy touch/button waveform, for board-level disturbance and self-test.
- On each start command it drives touch_out to a target level through a burst of pseudo-random-spaced bounce edges, then holds the level for a settle window.
- touch_out feeds the touch input of the team's debouncer on clk_out, so the full debounce path can be exercised without a human.

Parameters:
- BOUNCE_CNT, 3: bounce pairs per transition; 0 gives a clean single edge.
- GAP_MIN, 20'd1000: minimum cycles between bounce edges; must be >= 1.
- GAP_MASK, 16'h0FFF: mask applied to the LFSR for the random gap part; 0 gives deterministic gaps.
- SETTLE, 20'd600000: hold cycles after the last edge; must be >= 1 and exceed the 500000-cycle debounce window.
- LFSR_SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- INIT_LEVEL, 1'b0: touch_out value at reset.

Ports:
- clk_out  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command; sampled only in IDLE.
- level  in  1  target level, captured when start is accepted.
- touch_out  out  1  generated bouncy touch signal (registered).
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at end of sequence.
- edge_idx  out  4  number of bounce toggles issued in the current sequence.

Behaviour:
- Reset values: touch_out=INIT_LEVEL, busy=0, done=0, edge_idx=0, state=IDLE, LFSR=LFSR_SEED (or 1 if the seed is 0), counters=0. Reset mid-sequence aborts immediately with no done pulse.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle, including in IDLE.
- gap = GAP_MIN + (lfsr & GAP_MASK), zero-extended to 20 bits. GAP_MIN + GAP_MASK < 2^20 is a legal-parameter requirement, so no wrap occurs.
- States are IDLE, BOUNCE, SETTLE.
- IDLE, start=1 at edge t (acceptance):
  - level_q <= level; busy <= 1; edge_idx <= 0.
  - If level == touch_out: no toggles; state -> SETTLE with the settle counter at 0, so done pulses at edge t+1 and touch_out is unchanged.
  - Else: touch_out <= level (first contact) at edge t.
    - If BOUNCE_CNT==0: state -> SETTLE, counter <= SETTLE-1.
    - Else: state -> BOUNCE, gap counter <= gap-1.
- BOUNCE:
  - The gap counter decrements each cycle.
  - At an edge where it is 0: touch_out <= ~touch_out; edge_idx++; counter reloads gap-1 from the current LFSR.
  - Toggles alternate away from and back to level_q.
  - After toggle number 2*BOUNCE_CNT, touch_out==level_q; state -> SETTLE, counter <= SETTLE-1.
- SETTLE:
  - Counter decrements each cycle; touch_out is held.
  - At an edge where it is 0: busy <= 0, done <= 1 for exactly one cycle, state -> IDLE.
- Timing with fixed gap G, from acceptance edge t:
  - Toggles at t+G, t+2G, ..., t+2*BOUNCE_CNT*G.
  - done at t+2*BOUNCE_CNT*G+SETTLE.
- start while busy is ignored (no queueing). start in the same cycle that done is high is accepted, since the state is already IDLE.
- level changes after acceptance are ignored.
- edge_idx holds its value after done until the next acceptance.

Decomposition:
- Package touch_gen_pkg holds:
  - state localparams: IDLE=2'd0, BOUNCE=2'd1, SETTLE=2'd2;
  - LFSR taps constant 16'hB400;
  - zero-seed substitute 16'h0001.
- One sub-module: lfsr16_galois (clk_out, rst, seed parameter, 16-bit state output).

Test Plan:
- Deterministic burst (BOUNCE_CNT=2, GAP_MIN=4, GAP_MASK=0, SETTLE=10, touch_out=0), start with level=1 at t:
  - touch_out =1@t, 0@t+4, 1@t+8, 0@t+12, 1@t+16;
  - done pulse at t+26; busy high t+1..t+26; edge_idx=4.
- Clean edge (BOUNCE_CNT=0, SETTLE=10), start with level=1 at t -> touch_out=1@t, single edge, done@t+10.
- No-op: start with level==touch_out -> no toggles, done@t+1, edge_idx=0.
- start pulses while busy, plus start coincident with done:
  - pulses while busy are ignored, with timing unchanged;
  - the coincident start is accepted, and the new sequence begins at that edge.
- Reset at t+9 of the first scenario -> touch_out=INIT_LEVEL, busy=0, no done; the next start behaves identically to the first run.
- Random gaps with defaults, looped into a debouncer with a 500000-cycle window:
  - each gap lies in [1000, 1000+4095];
  - exactly one debouncer output toggle per sequence, 10 sequences.
